// File: rtl/multi_sync_capture.sv
// Multi-channel asynchronous input synchronizer with optional glitch filter,
// per-channel level/edge detection and a strobed bus capture with ready/valid handoff.
module multi_sync_capture #(
  parameter int NCH      = 8,
  parameter int STAGES   = 2,
  parameter int FILT_CNT = 0,
  parameter int DW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NCH-1:0]    async_in,
  input  logic [2*NCH-1:0]  mode,
  output logic [NCH-1:0]    ch_out,
  input  logic [DW-1:0]     data_in,
  input  logic              data_stb,
  output logic [DW-1:0]     data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overrun,
  input  logic              clr_ovr
);

  // Filtered lanes: NCH channels plus the strobe at index NCH.
  localparam int NF = NCH + 1;
  localparam int W  = NF + DW;
  localparam logic [3:0] FILT_LAST = (FILT_CNT > 0) ? 4'(FILT_CNT - 1) : 4'd0;

  logic [W-1:0]   sync_q [STAGES];
  logic [W-1:0]   sync_d [STAGES];
  logic [NF-1:0]  filt_q, filt_d;
  logic [NF-1:0]  prev_q, prev_d;
  logic [3:0]     cnt_q [NF];
  logic [3:0]     cnt_d [NF];
  logic [NCH-1:0] ch_q, ch_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           ovr_q, ovr_d;

  logic [W-1:0]   sync_last;
  logic [NF-1:0]  sync_bits;
  logic [DW-1:0]  sync_data;
  logic           capture;

  assign sync_last = sync_q[STAGES-1];
  assign sync_bits = sync_last[NF-1:0];
  assign sync_data = sync_last[W-1:NF];

  always_comb begin
    sync_d[0] = {data_in, data_stb, async_in};
    for (int unsigned s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < NF; i++) begin
      cnt_d[i] = '0;
      if (FILT_CNT == 0) begin
        filt_d[i] = sync_bits[i];
      end else if (sync_bits[i] != filt_q[i]) begin
        if (cnt_q[i] == FILT_LAST) begin
          filt_d[i] = sync_bits[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
    prev_d = filt_q;
  end

  always_comb begin
    ch_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   ch_d[i] = filt_q[i];
        2'b01:   ch_d[i] = filt_q[i] & ~prev_q[i];
        2'b10:   ch_d[i] = ~filt_q[i] & prev_q[i];
        default: ch_d[i] = filt_q[i] ^ prev_q[i];
      endcase
    end
    if (!ena) ch_d = '0;
  end

  assign capture = ena & filt_q[NCH] & ~prev_q[NCH];

  // A capture against a held word is accepted only if that word is consumed in the same cycle.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (capture) begin
      if (!valid_q || data_ready) begin
        dout_d  = sync_data;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) sync_q[s] <= '0;
      for (int unsigned i = 0; i < NF; i++) cnt_q[i] <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      ch_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) sync_q[s] <= sync_d[s];
      for (int unsigned i = 0; i < NF; i++) cnt_q[i] <= cnt_d[i];
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      ch_q    <= ch_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ch_out     = ch_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule
